// File: rtl/shift_pipe_pkg.sv
// Mode encodings and shared helpers for the pipelined barrel shifter.
package shift_pkg;

  localparam logic [1:0] SHIFT_SLL = 2'b00;
  localparam logic [1:0] SHIFT_SRL = 2'b01;
  localparam logic [1:0] SHIFT_SRA = 2'b10;
  localparam logic [1:0] SHIFT_ROR = 2'b11;

  // Bit shifted into the vacated high positions of a right shift.
  function automatic logic fill_bit(input logic [1:0] mode, input logic msb);
    return (mode == SHIFT_SRA) ? msb : 1'b0;
  endfunction

endpackage

// File: rtl/shift_pipe_stage.sv
// One log-stage of the barrel shifter: conditional shift/rotate by DIST.
module shift_stage
  import shift_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DIST  = 1
) (
  input  logic [WIDTH-1:0] i_data,
  input  logic [1:0]       i_mode,
  input  logic             i_en,
  output logic [WIDTH-1:0] o_data
);

  logic w_fill;

  assign w_fill = fill_bit(i_mode, i_data[WIDTH-1]);

  always_comb begin
    o_data = i_data;
    if (i_en) begin
      case (i_mode)
        SHIFT_SLL: o_data = {i_data[WIDTH-DIST-1:0], {DIST{1'b0}}};
        SHIFT_SRL,
        SHIFT_SRA: o_data = {{DIST{w_fill}}, i_data[WIDTH-1:DIST]};
        SHIFT_ROR: o_data = {i_data[DIST-1:0], i_data[WIDTH-1:DIST]};
        default:   o_data = i_data;
      endcase
    end
  end

endmodule

// File: rtl/shift_pipe.sv
// Pipelined barrel shifter: one log-stage per slot, valid/ready handshake,
// opaque tag carried alongside each operation.
module shift_pipe
  import shift_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int TAG_W   = 5,
  localparam int LOG2W  = $clog2(WIDTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [LOG2W-1:0] in_shamt,
  input  logic [1:0]       in_mode,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  logic [LOG2W-1:0] r_valid;
  logic [WIDTH-1:0] r_data  [LOG2W];
  logic [LOG2W-1:0] r_shamt [LOG2W];
  logic [1:0]       r_mode  [LOG2W];
  logic [TAG_W-1:0] r_tag   [LOG2W];

  logic [LOG2W-1:0] w_src_valid;
  logic [WIDTH-1:0] w_src_data  [LOG2W];
  logic [LOG2W-1:0] w_src_shamt [LOG2W];
  logic [1:0]       w_src_mode  [LOG2W];
  logic [TAG_W-1:0] w_src_tag   [LOG2W];
  logic [WIDTH-1:0] w_shifted   [LOG2W];
  logic [LOG2W:0]   w_free;

  // Slot k's source is the input port for S0, otherwise slot k-1.
  always_comb begin
    w_src_valid[0] = in_valid;
    w_src_data[0]  = in_data;
    w_src_shamt[0] = in_shamt;
    w_src_mode[0]  = in_mode;
    w_src_tag[0]   = in_tag;
    for (int k = 1; k < LOG2W; k++) begin
      w_src_valid[k] = r_valid[k-1];
      w_src_data[k]  = r_data[k-1];
      w_src_shamt[k] = r_shamt[k-1];
      w_src_mode[k]  = r_mode[k-1];
      w_src_tag[k]   = r_tag[k-1];
    end
  end

  // A slot can load when it is empty or its content moves on this cycle.
  always_comb begin
    w_free        = '0;
    w_free[LOG2W] = out_ready;
    for (int k = LOG2W - 1; k >= 0; k--) begin
      w_free[k] = !r_valid[k] || w_free[k+1];
    end
  end

  for (genvar k = 0; k < LOG2W; k++) begin : g_stage
    shift_stage #(
      .WIDTH (WIDTH),
      .DIST  (1 << k)
    ) u_stage (
      .i_data (w_src_data[k]),
      .i_mode (w_src_mode[k]),
      .i_en   (w_src_shamt[k][k]),
      .o_data (w_shifted[k])
    );
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_valid <= '0;
      for (int k = 0; k < LOG2W; k++) begin
        r_data[k]  <= '0;
        r_shamt[k] <= '0;
        r_mode[k]  <= SHIFT_SLL;
        r_tag[k]   <= '0;
      end
    end else begin
      for (int k = 0; k < LOG2W; k++) begin
        if (flush) begin
          r_valid[k] <= 1'b0;
        end else if (w_free[k]) begin
          r_valid[k] <= w_src_valid[k];
        end
        if (w_free[k]) begin
          r_data[k]  <= w_shifted[k];
          r_shamt[k] <= w_src_shamt[k];
          r_mode[k]  <= w_src_mode[k];
          r_tag[k]   <= w_src_tag[k];
        end
      end
    end
  end

  // During flush the offered input is discarded, so the producer is released.
  assign in_ready  = w_free[0] || flush;
  assign out_valid = r_valid[LOG2W-1];
  assign out_data  = r_data[LOG2W-1];
  assign out_tag   = r_tag[LOG2W-1];
  assign busy      = |r_valid;

endmodule

// File: tb/tb_shift_pipe.sv
// Scoreboard bench for shift_pipe at WIDTH=32 and WIDTH=8 side by side.
module tb_shift_pipe;

  localparam int W32 = 32;
  localparam int W8  = 8;
  localparam int L32 = 5;
  localparam int L8  = 3;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset, flush;
  logic        in_valid, in_ready, out_valid, out_ready, busy;
  logic [31:0] in_data, out_data;
  logic [4:0]  in_shamt, in_tag, out_tag;
  logic [1:0]  in_mode;

  logic        in_valid8, in_ready8, out_valid8, out_ready8, busy8;
  logic [7:0]  in_data8, out_data8;
  logic [2:0]  in_shamt8;
  logic [4:0]  in_tag8, out_tag8;
  logic [1:0]  in_mode8;

  shift_pipe #(.WIDTH(W32), .TAG_W(5)) u_dut32 (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_shamt(in_shamt), .in_mode(in_mode), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_tag(out_tag), .busy(busy)
  );

  shift_pipe #(.WIDTH(W8), .TAG_W(5)) u_dut8 (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(in_valid8), .in_ready(in_ready8), .in_data(in_data8),
    .in_shamt(in_shamt8), .in_mode(in_mode8), .in_tag(in_tag8),
    .out_valid(out_valid8), .out_ready(out_ready8), .out_data(out_data8),
    .out_tag(out_tag8), .busy(busy8)
  );

  typedef struct {
    logic [31:0] data;
    logic [31:0] tag;
    int          cyc;
    bit          lat;
  } exp_t;

  exp_t        q32[$];
  exp_t        q8[$];
  int          n_assert = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  bit          lat_chk  = 1'b0;
  bit          fire32   = 1'b0;
  bit          fire8    = 1'b0;
  bit          use_lit32 = 1'b0;
  bit          use_lit8  = 1'b0;
  logic [31:0] lit32, lit8;

  // Bit-by-bit reference: each result bit is picked directly from the operand.
  function automatic logic [31:0] ref_shift(input int w, input logic [31:0] d,
                                            input int sh, input logic [1:0] m);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < w; i++) begin
      case (m)
        2'b00:   r[i] = (i >= sh) ? d[i-sh] : 1'b0;
        2'b01:   r[i] = (i + sh < w) ? d[i+sh] : 1'b0;
        2'b10:   r[i] = (i + sh < w) ? d[i+sh] : d[w-1];
        default: r[i] = d[(i + sh) % w];
      endcase
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // One clock: compare/record at the falling edge, return 1 time unit after the rise.
  task automatic tick();
    exp_t e;
    @(negedge clock);
    if (out_valid && out_ready) begin
      if (q32.size() == 0) chk("spurious_out32", 32'(out_valid), 32'd0);
      else begin
        e = q32.pop_front();
        chk("data32", out_data, e.data);
        chk("tag32", 32'(out_tag), e.tag);
        if (e.lat) chk("latency32", cyc - e.cyc, L32);
      end
    end
    if (out_valid8 && out_ready8) begin
      if (q8.size() == 0) chk("spurious_out8", 32'(out_valid8), 32'd0);
      else begin
        e = q8.pop_front();
        chk("data8", 32'(out_data8), e.data);
        chk("tag8", 32'(out_tag8), e.tag);
        if (e.lat) chk("latency8", cyc - e.cyc, L8);
      end
    end
    fire32 = in_valid && in_ready && !flush && !reset;
    fire8  = in_valid8 && in_ready8 && !flush && !reset;
    if (fire32) begin
      e.data = use_lit32 ? lit32 : ref_shift(W32, in_data, int'(in_shamt), in_mode);
      e.tag  = 32'(in_tag);
      e.cyc  = cyc;
      e.lat  = lat_chk;
      q32.push_back(e);
    end
    if (fire8) begin
      e.data = use_lit8 ? lit8 : ref_shift(W8, 32'(in_data8), int'(in_shamt8), in_mode8);
      e.tag  = 32'(in_tag8);
      e.cyc  = cyc;
      e.lat  = lat_chk;
      q8.push_back(e);
    end
    if (reset || flush) begin
      q32.delete();
      q8.delete();
    end
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic issue32(input logic [31:0] d, input logic [4:0] sh, input logic [1:0] m,
                         input logic [4:0] tg, input logic [31:0] expv);
    in_valid = 1'b1; in_data = d; in_shamt = sh; in_mode = m; in_tag = tg;
    use_lit32 = 1'b1; lit32 = expv;
    tick();
    use_lit32 = 1'b0;
    chk("issue_accepted32", 32'(fire32), 32'd1);
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    in_valid = 1'b0; in_valid8 = 1'b0; out_ready = 1'b1; out_ready8 = 1'b1;
    while ((q32.size() != 0 || q8.size() != 0 || busy || busy8) && n < budget) begin
      tick();
      n++;
    end
    chk("drain_left", 32'(q32.size() + q8.size()), 32'd0);
    chk("drain_busy", {30'b0, busy, busy8}, 32'd0);
  endtask

  task automatic post_kill_checks(input string name);
    chk({name, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({name, "_busy"}, 32'(busy), 32'd0);
    for (int c = 0; c < 8; c++) begin
      tick();
      chk({name, "_quiet"}, 32'(out_valid), 32'd0);
    end
    lat_chk = 1'b1;
    issue32(32'h0000_00F0, 5'd4, 2'b01, 5'd30, 32'h0000_000F);
    in_valid = 1'b0;
    drain(20);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int idx, acc, n;
    bit have_hold, gen;
    logic [31:0] hold;

    reset = 1'b1; flush = 1'b0;
    in_valid = 1'b0; in_data = '0; in_shamt = '0; in_mode = '0; in_tag = '0; out_ready = 1'b1;
    in_valid8 = 1'b0; in_data8 = '0; in_shamt8 = '0; in_mode8 = '0; in_tag8 = '0; out_ready8 = 1'b1;
    repeat (3) tick();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_out_tag", 32'(out_tag), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_busy8", 32'(busy8), 32'd0);
    reset = 1'b0;
    tick();

    // SRA with exact latency and tag
    lat_chk = 1'b1;
    issue32(32'h8000_0000, 5'd4, 2'b10, 5'h15, 32'hF800_0000);
    in_valid = 1'b0;
    drain(20);

    // All modes back to back, including shift by zero
    issue32(32'h0000_0001, 5'd31, 2'b00, 5'd1, 32'h8000_0000);
    issue32(32'h8000_0000, 5'd31, 2'b01, 5'd2, 32'h0000_0001);
    issue32(32'h0000_0001, 5'd1,  2'b11, 5'd3, 32'h8000_0000);
    issue32(32'h1234_5678, 5'd0,  2'b11, 5'd4, 32'h1234_5678);
    issue32(32'hC000_0003, 5'd0,  2'b10, 5'd5, 32'hC000_0003);
    in_valid = 1'b0;
    drain(20);

    // Throughput: 8 back-to-back, results on consecutive cycles
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_data = 32'hF0F0_1234 + 32'(i);
      in_shamt = 5'(i * 3); in_mode = 2'(i); in_tag = 5'(i);
      #1;
      chk("tput_in_ready", 32'(in_ready), 32'd1);
      tick();
    end
    in_valid = 1'b0;
    drain(20);

    // Backpressure: fill while stalled, then release
    out_ready = 1'b0; lat_chk = 1'b0; idx = 0; acc = 0; have_hold = 1'b0; hold = '0;
    for (int c = 0; c < 8; c++) begin
      in_valid = (idx < 6); in_data = 32'hA5A5_0F00 + 32'(idx);
      in_shamt = 5'(idx + 1); in_mode = 2'(idx); in_tag = 5'(idx + 8);
      tick();
      if (fire32) begin idx++; acc++; end
      if (out_valid) begin
        if (!have_hold) begin hold = out_data; have_hold = 1'b1; end
        else chk("stall_stable", out_data, hold);
      end
    end
    chk("bp_accepted", 32'(acc), 32'd5);
    chk("bp_in_ready", 32'(in_ready), 32'd0);
    chk("bp_head", hold, ref_shift(W32, 32'hA5A5_0F00, 1, 2'b00));
    out_ready = 1'b1; n = 0;
    while (idx < 6 && n < 20) begin
      in_valid = 1'b1; in_data = 32'hA5A5_0F00 + 32'(idx);
      in_shamt = 5'(idx + 1); in_mode = 2'(idx); in_tag = 5'(idx + 8);
      tick();
      if (fire32) idx++;
      n++;
    end
    chk("bp_resume", 32'(idx), 32'd6);
    in_valid = 1'b0;
    drain(30);

    // Flush with 3 in flight; offered input is dropped
    lat_chk = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = 32'h1111_0000 << i; in_shamt = 5'd2; in_mode = 2'b11; in_tag = 5'(20 + i);
      tick();
    end
    flush = 1'b1; in_valid = 1'b1; in_data = 32'hDEAD_BEEF; in_tag = 5'd23;
    #1;
    chk("flush_in_ready", 32'(in_ready), 32'd1);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    post_kill_checks("flush");

    // Reset with 3 in flight
    lat_chk = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = 32'h0F0F_0000 + 32'(i); in_shamt = 5'd1; in_mode = 2'b00; in_tag = 5'(24 + i);
      tick();
    end
    in_valid = 1'b0; reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("reset_out_data", out_data, 32'd0);
    chk("reset_out_tag", 32'(out_tag), 32'd0);
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    post_kill_checks("reset");

    // WIDTH=8 directed SRA
    lat_chk = 1'b1;
    in_valid8 = 1'b1; in_data8 = 8'h90; in_shamt8 = 3'd3; in_mode8 = 2'b10; in_tag8 = 5'd9;
    use_lit8 = 1'b1; lit8 = 32'h0000_00F2;
    tick();
    use_lit8 = 1'b0;
    in_valid8 = 1'b0;
    drain(10);

    // Random traffic on both widths with random backpressure
    lat_chk = 1'b0;
    for (int c = 0; c < 90; c++) begin
      gen = (c < 80);
      if (!in_valid || fire32) begin
        in_valid = gen && ($urandom_range(0, 3) != 0);
        in_data = $urandom; in_shamt = 5'($urandom_range(0, 31));
        in_mode = 2'($urandom_range(0, 3)); in_tag = 5'($urandom_range(0, 31));
      end
      if (!in_valid8 || fire8) begin
        in_valid8 = gen && ($urandom_range(0, 3) != 0);
        in_data8 = 8'($urandom); in_shamt8 = 3'($urandom_range(0, 7));
        in_mode8 = 2'($urandom_range(0, 3)); in_tag8 = 5'($urandom_range(0, 31));
      end
      out_ready  = !gen || ($urandom_range(0, 3) != 0);
      out_ready8 = !gen || ($urandom_range(0, 3) != 0);
      tick();
    end
    drain(40);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
